// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the pipeline MEM stage (CPU port)
// and the CNN accelerator burst port. The CPU has fixed priority and sees the
// memory as a combinational pass-through. The accelerator is granted word
// bursts of up to BURST_MAX beats, either when the CPU is idle or once its
// request has waited STARVE_LIMIT cycles.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   cpu_memread/cpu_memwrite   MEM-stage load/store strobes
//   cpu_address/cpu_writedata  MEM-stage byte address and store data
//   cpu_readdata               load data, 0 unless a load is served this cycle
//   cpu_stall                  CPU access not performed this cycle
//   acc_req/acc_write          burst request and direction (held until acc_gnt)
//   acc_addr/acc_len           burst start byte address and beat count
//   acc_gnt                    one-cycle pulse, request fields latched
//   acc_wdata/acc_wready       write-beat data and its consume strobe
//   acc_rdata/acc_rvalid       registered read-beat data and valid
//   acc_done                   one-cycle pulse after the last beat
//   mem_*                      data memory pins, owned by this block
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BURST_MAX    = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_memread,
    input  logic              cpu_memwrite,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_stall,
    input  logic              acc_req,
    input  logic              acc_write,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [4:0]        acc_len,
    output logic              acc_gnt,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_wready,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              acc_rvalid,
    output logic              acc_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_readdata
);

    // Wide enough to hold STARVE_LIMIT itself; the counter saturates there.
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 2);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   base_r;
    logic [4:0]          len_r;
    logic                write_r;
    logic [4:0]          beat_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                done_r;
    logic                rvalid_r;
    logic [DATA_W-1:0]   rdata_r;

    logic                cpu_req_s;
    logic                starved_s;
    logic                grant_s;
    logic [4:0]          len_clamp_s;
    logic                last_beat_s;
    logic [ADDR_W-1:0]   burst_addr_s;

    assign cpu_req_s    = cpu_memread | cpu_memwrite;
    assign starved_s    = (wait_cnt_r >= WAIT_W'(STARVE_LIMIT));
    // Grants are only issued from IDLE and never while reset is held.
    assign grant_s      = (state_r == ST_IDLE) & acc_req & (~cpu_req_s | starved_s) & ~reset;
    assign len_clamp_s  = (acc_len > 5'(BURST_MAX)) ? 5'(BURST_MAX) : acc_len;
    assign last_beat_s  = (beat_cnt_r == (len_r - 5'd1));
    // Beat stride is one word; the add wraps naturally at the address width.
    assign burst_addr_s = base_r + ADDR_W'({beat_cnt_r, 2'b00});

    assign acc_done   = done_r;
    assign acc_rvalid = rvalid_r;
    assign acc_rdata  = rdata_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a null burst is granted but never leaves IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s && (len_clamp_s != 5'd0)) begin
                    state_next_s = ST_BURST;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (last_beat_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BURST;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Burst bookkeeping, starvation counter and registered accelerator outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r     <= '0;
            len_r      <= 5'd0;
            write_r    <= 1'b0;
            beat_cnt_r <= 5'd0;
            wait_cnt_r <= '0;
            done_r     <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= '0;
        end else begin
            done_r   <= 1'b0;
            rvalid_r <= 1'b0;
            if (grant_s) begin
                base_r     <= acc_addr;
                len_r      <= len_clamp_s;
                write_r    <= acc_write;
                beat_cnt_r <= 5'd0;
                wait_cnt_r <= '0;
                if (len_clamp_s == 5'd0) begin
                    done_r <= 1'b1;
                end
            end else if ((state_r == ST_IDLE) && acc_req && !starved_s) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
            if (state_r == ST_BURST) begin
                if (last_beat_s) begin
                    beat_cnt_r <= 5'd0;
                    done_r     <= 1'b1;
                end else begin
                    beat_cnt_r <= beat_cnt_r + 5'd1;
                end
                if (!write_r) begin
                    rdata_r  <= mem_readdata;
                    rvalid_r <= 1'b1;
                end
            end
        end
    end

    // Memory pin mux and CPU-side handshake; reset silences every strobe at once.
    always_comb begin
        mem_address   = cpu_address;
        mem_writedata = cpu_writedata;
        mem_memread   = 1'b0;
        mem_memwrite  = 1'b0;
        cpu_readdata  = '0;
        cpu_stall     = 1'b0;
        acc_gnt       = 1'b0;
        acc_wready    = 1'b0;
        if (reset) begin
            mem_memread  = 1'b0;
            mem_memwrite = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_memread  = cpu_memread;
                    mem_memwrite = cpu_memwrite;
                    cpu_readdata = cpu_memread ? mem_readdata : '0;
                    acc_gnt      = grant_s;
                end
                ST_BURST: begin
                    mem_address   = burst_addr_s;
                    mem_writedata = acc_wdata;
                    mem_memread   = ~write_r;
                    mem_memwrite  = write_r;
                    cpu_stall     = cpu_req_s;
                    acc_wready    = write_r;
                end
                default: begin
                    mem_memread  = 1'b0;
                    mem_memwrite = 1'b0;
                end
            endcase
        end
    end

endmodule
